// File: rtl/RS5_pkg.sv
// Shared RS5 types for the plugin dispatch stage.
// Holds the dispatcher state encoding and default watchdog limit.
package RS5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } plugin_dispatch_state_e;

  localparam int unsigned PLUGIN_DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/plugin_dispatch.sv
// Sequencer between execute and a start/busy/done coprocessor plugin.
// Optional watchdog abort when PLUGIN_TIMEOUT_EN is defined.
module plugin_dispatch
  import RS5_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PLUGIN_DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        plugin_start,
  output logic [31:0] plugin_a,
  output logic [31:0] plugin_b,
  input  logic [31:0] plugin_result,
  input  logic        plugin_busy,
  input  logic        plugin_done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        hold
);

  plugin_dispatch_state_e state, state_n;

  logic cap_req;
  logic cap_res;
  logic cap_tmo;
  logic tmo;
  logic unused;

  always_comb begin
    state_n = state;
    cap_req = 1'b0;
    cap_res = 1'b0;
    cap_tmo = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          state_n = ISSUE;
          cap_req = 1'b1;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_n = plugin_done ? IDLE : DRAIN;
        end else if (plugin_done) begin
          state_n = RESP;
          cap_res = 1'b1;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        // A done coinciding with flush has already retired the op.
        if (flush) begin
          state_n = plugin_done ? IDLE : DRAIN;
        end else if (plugin_done) begin
          state_n = RESP;
          cap_res = 1'b1;
        end else if (tmo) begin
          state_n = RESP;
          cap_tmo = 1'b1;
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (plugin_done || tmo) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      plugin_a  <= '0;
      plugin_b  <= '0;
      resp_rd   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_n;
      if (cap_req) begin
        plugin_a <= req_rs1;
        plugin_b <= req_rs2;
        resp_rd  <= req_rd;
      end
      if (cap_res) begin
        resp_data <= plugin_result;
      end else if (cap_tmo) begin
        resp_data <= '0;
      end
    end
  end

`ifdef PLUGIN_TIMEOUT_EN
  logic [15:0] cnt;
  logic        err_q;

  assign tmo = (cnt == 16'(TIMEOUT_CYCLES - 1));

  // Restarts whenever a new state is entered; only WAIT/DRAIN use it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (state == WAIT || state == DRAIN) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cap_res) begin
      err_q <= 1'b0;
    end else if (cap_tmo) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err = err_q;
  assign unused   = plugin_busy;
`else
  assign tmo      = 1'b0;
  assign resp_err = 1'b0;
  assign unused   = ^{plugin_busy, 32'(TIMEOUT_CYCLES)};
`endif

  assign req_ready    = (state == IDLE);
  assign plugin_start = (state == ISSUE);
  assign resp_valid   = (state == RESP);
  assign hold         = (state != IDLE);

endmodule
